// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants, op-mode type and slice sizing for the pipelined CLA adder
package adder_pkg;

    localparam int GROUP_W = 4;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_mode_e;

    function automatic int slice_width(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/cla_slice.sv
// rtl/cla_slice.sv - combinational SLICE-bit adder built from 4-bit lookahead groups
module cla_slice
    import adder_pkg::*;
#(
    parameter int SLICE = 16
) (
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    input  logic             cin_i,
    output logic [SLICE-1:0] sum_o,
    output logic             cout_o,
    output logic             msb_p_o,
    output logic             msb_g_o
);

    localparam int NG = SLICE / GROUP_W;

    logic [SLICE-1:0] g, p, c;
    logic [NG-1:0]    grp_g, grp_p;
    logic [NG:0]      grp_c;
    logic             grp_run, cla_run, bit_run;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    always_comb begin
        grp_g   = '0;
        grp_p   = '0;
        grp_run = 1'b1;
        for (int j = 0; j < NG; j++) begin
            grp_run = 1'b1;
            for (int i = GROUP_W - 1; i >= 0; i--) begin
                grp_g[j] = grp_g[j] | (g[j*GROUP_W+i] & grp_run);
                grp_run  = grp_run & p[j*GROUP_W+i];
            end
            grp_p[j] = grp_run;
        end
    end

    // Every group carry is a flat sum of products over the lower groups and cin.
    always_comb begin
        grp_c   = '0;
        cla_run = 1'b1;
        for (int j = 0; j <= NG; j++) begin
            cla_run = 1'b1;
            for (int i = j - 1; i >= 0; i--) begin
                grp_c[j] = grp_c[j] | (grp_g[i] & cla_run);
                cla_run  = cla_run & grp_p[i];
            end
            grp_c[j] = grp_c[j] | (cla_run & cin_i);
        end
    end

    always_comb begin
        c       = '0;
        bit_run = 1'b1;
        for (int j = 0; j < NG; j++) begin
            for (int i = 0; i < GROUP_W; i++) begin
                bit_run = 1'b1;
                for (int k = i - 1; k >= 0; k--) begin
                    c[j*GROUP_W+i] = c[j*GROUP_W+i] | (g[j*GROUP_W+k] & bit_run);
                    bit_run        = bit_run & p[j*GROUP_W+k];
                end
                c[j*GROUP_W+i] = c[j*GROUP_W+i] | (bit_run & grp_c[j]);
            end
        end
    end

    assign sum_o   = p ^ c;
    assign cout_o  = grp_c[NG];
    assign msb_p_o = p[SLICE-1];
    assign msb_g_o = g[SLICE-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// rtl/pipelined_cla_adder.sv - STAGES-deep pipelined CLA adder/subtractor with global-stall handshake
module pipelined_cla_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] num1_i,
    input  logic [WIDTH-1:0] num2_i,
    input  logic             carry_i,
    input  logic             sub_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             overflow_o
);

    localparam int SLICE = slice_width(WIDTH, STAGES);

    logic advance;

    assign advance = ~valid_o | ready_i;
    assign ready_o = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO  = k * SLICE;
        localparam int REM = WIDTH - LO;

        logic [REM-1:0]      rem_a, rem_b;
        logic [LO+SLICE-1:0] sum_d, sum_q;
        logic [SLICE-1:0]    s_sum, b_eff;
        op_mode_e            op_s;
        logic                cin_s, vld_s, cout_s, msb_p, msb_g;
        logic                vld_q, c_q;

        if (k == 0) begin : g_head
            assign rem_a = num1_i;
            assign rem_b = num2_i;
            assign op_s  = op_mode_e'(sub_i);
            assign cin_s = (op_s == OP_SUB) ? 1'b1 : carry_i;
            assign vld_s = valid_i;
            assign sum_d = s_sum;
        end else begin : g_tail
            assign rem_a = g_stage[k-1].g_fwd.a_q;
            assign rem_b = g_stage[k-1].g_fwd.b_q;
            assign op_s  = g_stage[k-1].g_fwd.op_q;
            assign cin_s = g_stage[k-1].c_q;
            assign vld_s = g_stage[k-1].vld_q;
            assign sum_d = {s_sum, g_stage[k-1].sum_q};
        end

        assign b_eff = (op_s == OP_SUB) ? ~rem_b[SLICE-1:0] : rem_b[SLICE-1:0];

        cla_slice #(
            .SLICE(SLICE)
        ) u_slice (
            .a_i    (rem_a[SLICE-1:0]),
            .b_i    (b_eff),
            .cin_i  (cin_s),
            .sum_o  (s_sum),
            .cout_o (cout_s),
            .msb_p_o(msb_p),
            .msb_g_o(msb_g)
        );

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                vld_q <= 1'b0;
                c_q   <= 1'b0;
                sum_q <= '0;
            end else if (advance) begin
                vld_q <= vld_s;
                c_q   <= cout_s;
                sum_q <= sum_d;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            // Only the operand bits not yet consumed travel on to later stages.
            logic [REM-SLICE-1:0] a_q, b_q;
            op_mode_e             op_q;
            logic                 unused_msb;

            assign unused_msb = msb_p ^ msb_g;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    a_q  <= '0;
                    b_q  <= '0;
                    op_q <= OP_ADD;
                end else if (advance) begin
                    a_q  <= rem_a[REM-1:SLICE];
                    b_q  <= rem_b[REM-1:SLICE];
                    op_q <= op_s;
                end
            end
        end else begin : g_last
            logic ovf_q;

            // With the MSB propagate clear, A and B' agree there and the generate bit equals A's MSB.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    ovf_q <= 1'b0;
                end else if (advance) begin
                    ovf_q <= ~msb_p & (s_sum[SLICE-1] ^ msb_g);
                end
            end
        end
    end

    assign valid_o    = g_stage[STAGES-1].vld_q;
    assign sum_o      = g_stage[STAGES-1].sum_q;
    assign carry_o    = g_stage[STAGES-1].c_q;
    assign overflow_o = g_stage[STAGES-1].g_last.ovf_q;

endmodule
